// File: rtl/rat_pkg.sv
// Shared definitions for the rational-unit arbiter: operation encodings and FSM states.
package rat_pkg;

  localparam logic RAT_ADD = 1'b0;
  localparam logic RAT_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } rat_state_e;

endpackage

// File: rtl/rat_rr_pick.sv
// Round-robin picker: scans upward from the slot after last_i, wrapping around,
// and reports the first active requester as a one-hot grant and an index.
module rat_rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [IDW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(last_i) + i) % NREQ);
      if (!any_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rat_arbiter.sv
// Round-robin arbiter sharing one rational add/sub unit among NREQ requesters.
// Build option: define RAT_ARB_ZERO_DEN_CHK_EN to answer zero-denominator requests with resp_err.
module rat_arbiter
  import rat_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_l_num,
  input  logic [NREQ*WIDTH-1:0] req_l_den,
  input  logic [NREQ*WIDTH-1:0] req_r_num,
  input  logic [NREQ*WIDTH-1:0] req_r_den,
  output logic                  u_start,
  output logic                  u_op,
  output logic [WIDTH-1:0]      u_l_num,
  output logic [WIDTH-1:0]      u_l_den,
  output logic [WIDTH-1:0]      u_r_num,
  output logic [WIDTH-1:0]      u_r_den,
  input  logic                  u_rdy,
  input  logic [WIDTH-1:0]      u_s_num,
  input  logic [WIDTH-1:0]      u_s_den,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_num,
  output logic [WIDTH-1:0]      resp_den,
  output logic                  resp_err
);

  rat_state_e       state_q;
  logic [IDW-1:0]   lastGrant_q;
  logic             u_start_q;
  logic             u_op_q;
  logic [WIDTH-1:0] u_l_num_q;
  logic [WIDTH-1:0] u_l_den_q;
  logic [WIDTH-1:0] u_r_num_q;
  logic [WIDTH-1:0] u_r_den_q;
  logic             resp_valid_q;
  logic [IDW-1:0]   resp_id_q;
  logic [WIDTH-1:0] resp_num_q;
  logic [WIDTH-1:0] resp_den_q;

  logic [NREQ-1:0]  pickGnt;
  logic [IDW-1:0]   pickIdx;
  logic             pickAny;
  logic             grantFire;
  logic             zeroDen;

  logic             selOp;
  logic [WIDTH-1:0] selLNum;
  logic [WIDTH-1:0] selLDen;
  logic [WIDTH-1:0] selRNum;
  logic [WIDTH-1:0] selRDen;

  rat_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req_i  (req_valid),
    .last_i (lastGrant_q),
    .gnt_o  (pickGnt),
    .idx_o  (pickIdx),
    .any_o  (pickAny)
  );

  // Gating with rst keeps req_ready low while reset holds the FSM in IDLE.
  assign grantFire = (state_q == IDLE) && pickAny && rst;
  assign req_ready = grantFire ? pickGnt : '0;

  always_comb begin
    selOp   = RAT_ADD;
    selLNum = '0;
    selLDen = '0;
    selRNum = '0;
    selRDen = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pickIdx == IDW'(k)) begin
        selOp   = req_op[k];
        selLNum = req_l_num[k*WIDTH +: WIDTH];
        selLDen = req_l_den[k*WIDTH +: WIDTH];
        selRNum = req_r_num[k*WIDTH +: WIDTH];
        selRDen = req_r_den[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef RAT_ARB_ZERO_DEN_CHK_EN
  logic resp_err_q;
  assign zeroDen  = (selLDen == '0) || (selRDen == '0);
  assign resp_err = resp_err_q;
`else
  assign zeroDen  = 1'b0;
  assign resp_err = 1'b0;
`endif

  // u_start is raised on entry to ISSUE and dropped by the default on the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      lastGrant_q  <= IDW'(NREQ - 1);
      u_start_q    <= 1'b0;
      u_op_q       <= RAT_ADD;
      u_l_num_q    <= '0;
      u_l_den_q    <= '0;
      u_r_num_q    <= '0;
      u_r_den_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_num_q   <= '0;
      resp_den_q   <= '0;
`ifdef RAT_ARB_ZERO_DEN_CHK_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      u_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grantFire) begin
            lastGrant_q <= pickIdx;
            resp_id_q   <= pickIdx;
            u_op_q      <= selOp;
            u_l_num_q   <= selLNum;
            u_l_den_q   <= selLDen;
            u_r_num_q   <= selRNum;
            u_r_den_q   <= selRDen;
            if (zeroDen) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_num_q   <= '0;
              resp_den_q   <= '0;
`ifdef RAT_ARB_ZERO_DEN_CHK_EN
              resp_err_q   <= 1'b1;
`endif
            end else begin
              state_q   <= ISSUE;
              u_start_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (u_rdy) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_num_q   <= u_s_num;
            resp_den_q   <= u_s_den;
`ifdef RAT_ARB_ZERO_DEN_CHK_EN
            resp_err_q   <= 1'b0;
`endif
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
`ifdef RAT_ARB_ZERO_DEN_CHK_EN
            resp_err_q   <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign u_start    = u_start_q;
  assign u_op       = u_op_q;
  assign u_l_num    = u_l_num_q;
  assign u_l_den    = u_l_den_q;
  assign u_r_num    = u_r_num_q;
  assign u_r_den    = u_r_den_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_num   = resp_num_q;
  assign resp_den   = resp_den_q;

endmodule

// File: tb/tb_rat_arbiter.sv
// Bench for rat_arbiter: directed and random requester traffic checked against a
// round-robin reference model and a behavioural rational unit.
module tb_rat_arbiter;
  import rat_pkg::*;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int IDW   = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_op;
  logic [NREQ*WIDTH-1:0] req_l_num, req_l_den, req_r_num, req_r_den;
  logic                  u_start, u_op;
  logic [WIDTH-1:0]      u_l_num, u_l_den, u_r_num, u_r_den;
  logic                  u_rdy;
  logic [WIDTH-1:0]      u_s_num, u_s_den;
  logic                  resp_valid, resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_num, resp_den;
  logic                  resp_err;

  logic [WIDTH-1:0] sLNum [NREQ];
  logic [WIDTH-1:0] sLDen [NREQ];
  logic [WIDTH-1:0] sRNum [NREQ];
  logic [WIDTH-1:0] sRDen [NREQ];

  int checks    = 0;
  int failures  = 0;
  int lastGrant = NREQ - 1;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NREQ; k++) begin : g_pack
    assign req_l_num[k*WIDTH +: WIDTH] = sLNum[k];
    assign req_l_den[k*WIDTH +: WIDTH] = sLDen[k];
    assign req_r_num[k*WIDTH +: WIDTH] = sRNum[k];
    assign req_r_den[k*WIDTH +: WIDTH] = sRDen[k];
  end

  rat_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_l_num  (req_l_num),
    .req_l_den  (req_l_den),
    .req_r_num  (req_r_num),
    .req_r_den  (req_r_den),
    .u_start    (u_start),
    .u_op       (u_op),
    .u_l_num    (u_l_num),
    .u_l_den    (u_l_den),
    .u_r_num    (u_r_num),
    .u_r_den    (u_r_den),
    .u_rdy      (u_rdy),
    .u_s_num    (u_s_num),
    .u_s_den    (u_s_den),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_num   (resp_num),
    .resp_den   (resp_den),
    .resp_err   (resp_err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Rational add/sub with results truncated to WIDTH bits: {numerator, denominator}.
  function automatic logic [2*WIDTH-1:0] ratCalc(input logic op, input logic [WIDTH-1:0] ln,
                                                 input logic [WIDTH-1:0] ld, input logic [WIDTH-1:0] rn,
                                                 input logic [WIDTH-1:0] rd);
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] d;
    n = (op == RAT_SUB) ? (ln * rd - rn * ld) : (ln * rd + rn * ld);
    d = ld * rd;
    return {n, d};
  endfunction

  function automatic int modelGrant(input logic [NREQ-1:0] v, input int last);
    int cand;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (last + i) % NREQ;
      if (v[IDW'(cand)]) return cand;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++) begin
      sLNum[k] = WIDTH'($urandom_range(0, 5000));
      sLDen[k] = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom_range(1, 5000));
      sRNum[k] = WIDTH'($urandom_range(0, 5000));
      sRDen[k] = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom_range(1, 5000));
      req_op[IDW'(k)] = 1'($urandom_range(0, 1));
    end
    req_valid = mask;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    checkOutput({tag, "_u_start"}, 64'(u_start), 64'(0));
    checkOutput({tag, "_u_op"}, 64'(u_op), 64'(0));
    checkOutput({tag, "_u_l_num"}, 64'(u_l_num), 64'(0));
    checkOutput({tag, "_u_l_den"}, 64'(u_l_den), 64'(0));
    checkOutput({tag, "_u_r_num"}, 64'(u_r_num), 64'(0));
    checkOutput({tag, "_u_r_den"}, 64'(u_r_den), 64'(0));
    checkOutput({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    checkOutput({tag, "_resp_id"}, 64'(resp_id), 64'(0));
    checkOutput({tag, "_resp_num"}, 64'(resp_num), 64'(0));
    checkOutput({tag, "_resp_den"}, 64'(resp_den), 64'(0));
    checkOutput({tag, "_resp_err"}, 64'(resp_err), 64'(0));
  endtask

  // Entered just after a rising edge with the DUT in IDLE and req_valid non-zero;
  // leaves just after the edge that returns the DUT to IDLE.
  task automatic runTxn(input int latency, input int stall);
    int                 g;
    logic [NREQ-1:0]    oh;
    logic               errPath;
    logic [2*WIDTH-1:0] expRes;
    logic [WIDTH-1:0]   eNum, eDen;
    g  = modelGrant(req_valid, lastGrant);
    oh = '0;
    oh[IDW'(g)] = 1'b1;
    errPath = 1'b0;
`ifdef RAT_ARB_ZERO_DEN_CHK_EN
    errPath = (sLDen[g] == '0) || (sRDen[g] == '0);
`endif
    expRes = ratCalc(req_op[IDW'(g)], sLNum[g], sLDen[g], sRNum[g], sRDen[g]);
    eNum = errPath ? '0 : expRes[2*WIDTH-1:WIDTH];
    eDen = errPath ? '0 : expRes[WIDTH-1:0];

    @(negedge clk);
    checkOutput("grant_ready", 64'(req_ready), 64'(oh));
    checkOutput("idle_start", 64'(u_start), 64'(0));
    checkOutput("idle_resp_valid", 64'(resp_valid), 64'(0));
    lastGrant = g;
    @(posedge clk); #1;
    // A unit-ready pulse outside WAIT must be ignored.
    u_rdy   = 1'b1;
    u_s_num = WIDTH'($urandom);
    u_s_den = WIDTH'($urandom);
    if (!errPath) begin
      @(negedge clk);
      checkOutput("issue_start", 64'(u_start), 64'(1));
      checkOutput("issue_ready", 64'(req_ready), 64'(0));
      checkOutput("issue_resp_valid", 64'(resp_valid), 64'(0));
      checkOutput("issue_op", 64'(u_op), 64'(req_op[IDW'(g)]));
      checkOutput("issue_l_num", 64'(u_l_num), 64'(sLNum[g]));
      checkOutput("issue_l_den", 64'(u_l_den), 64'(sLDen[g]));
      checkOutput("issue_r_num", 64'(u_r_num), 64'(sRNum[g]));
      checkOutput("issue_r_den", 64'(u_r_den), 64'(sRDen[g]));
      @(posedge clk); #1;
      u_rdy = 1'b0;
      for (int c = 0; c < latency; c++) begin
        @(negedge clk);
        checkOutput("wait_start", 64'(u_start), 64'(0));
        checkOutput("wait_resp_valid", 64'(resp_valid), 64'(0));
        @(posedge clk); #1;
      end
      {u_s_num, u_s_den} = ratCalc(u_op, u_l_num, u_l_den, u_r_num, u_r_den);
      u_rdy = 1'b1;
      @(posedge clk); #1;
      u_rdy   = 1'b0;
      u_s_num = WIDTH'($urandom);
      u_s_den = WIDTH'($urandom);
    end

    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      checkOutput("resp_valid", 64'(resp_valid), 64'(1));
      checkOutput("resp_id", 64'(resp_id), 64'(g));
      checkOutput("resp_num", 64'(resp_num), 64'(eNum));
      checkOutput("resp_den", 64'(resp_den), 64'(eDen));
      checkOutput("resp_err", 64'(resp_err), 64'(errPath));
      checkOutput("resp_start", 64'(u_start), 64'(0));
      checkOutput("resp_req_ready", 64'(req_ready), 64'(0));
      if (!errPath) checkOutput("resp_hold_l_den", 64'(u_l_den), 64'(sLDen[g]));
      u_rdy      = 1'b0;
      resp_ready = (s == stall);
      @(posedge clk); #1;
    end
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] mask;
    rst        = 1'b1;
    req_valid  = '0;
    req_op     = '0;
    u_rdy      = 1'b0;
    u_s_num    = '0;
    u_s_den    = '0;
    resp_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sLNum[k] = '0;
      sLDen[k] = '0;
      sRNum[k] = '0;
      sRDen[k] = '0;
    end
    #2 rst = 1'b0;
    applyStimulus('1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("por");
    @(posedge clk); #1;
    rst = 1'b1;

    $display("[TB] all requesters held valid: expecting grants 0,1,2,3,0");
    for (int t = 0; t < 5; t++) begin
      applyStimulus('1);
      runTxn(t % 3, 0);
    end

    $display("[TB] single request: requester 2 adds 1/2 + 1/3");
    applyStimulus(4'b0100);
    sLNum[2] = 1; sLDen[2] = 2; sRNum[2] = 1; sRDen[2] = 3;
    req_op[2] = RAT_ADD;
    runTxn(1, 0);

    $display("[TB] response back-pressure for 10 cycles");
    applyStimulus(4'b1000);
    sLDen[3] = 11; sRDen[3] = 13;
    runTxn(0, 10);

    $display("[TB] zero right denominator on requester 1 subtract");
    applyStimulus(4'b0010);
    req_op[1] = RAT_SUB;
    sLDen[1] = 7; sRDen[1] = 0;
    runTxn(1, 1);

    $display("[TB] random traffic");
    for (int t = 0; t < 40; t++) begin
      mask = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if (mask == '0) begin
        req_valid = '0;
        u_rdy     = 1'b1;
        u_s_num   = WIDTH'($urandom);
        @(negedge clk);
        checkOutput("idle_nomask_ready", 64'(req_ready), 64'(0));
        checkOutput("idle_nomask_start", 64'(u_start), 64'(0));
        checkOutput("idle_nomask_resp", 64'(resp_valid), 64'(0));
        @(posedge clk); #1;
        u_rdy = 1'b0;
      end else begin
        applyStimulus(mask);
        runTxn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    end

    $display("[TB] reset asserted while waiting on the unit");
    applyStimulus(4'b0010);
    sLDen[1] = 3; sRDen[1] = 5;
    @(negedge clk);
    checkOutput("rst_txn_grant", 64'(req_ready), 64'(1 << modelGrant(req_valid, lastGrant)));
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkReset("mid_wait_rst");
    req_valid = '0;
    @(posedge clk); #1;
    rst       = 1'b1;
    lastGrant = NREQ - 1;
    u_rdy     = 1'b1;
    u_s_num   = 123;
    u_s_den   = 456;
    @(negedge clk);
    checkOutput("post_rst_resp_valid", 64'(resp_valid), 64'(0));
    checkOutput("post_rst_start", 64'(u_start), 64'(0));
    @(posedge clk); #1;
    u_rdy = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("post_rst_quiet", 64'(resp_valid), 64'(0));
      @(posedge clk); #1;
    end
    applyStimulus('1);
    runTxn(2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rat_arbiter.md
RAT_ARBITER -- requirements
Module: rat_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the numerator and denominator bit width.
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 Port req_valid  input  NREQ  is the per-requester request strobe.
REQ-006 Port req_ready  output  NREQ  is the per-requester accept, one-hot or zero.
REQ-007 Port req_op  input  NREQ  is the per-requester operation: 0 = add, 1 = subtract.
REQ-008 Port req_l_num / req_l_den / req_r_num / req_r_den  input  NREQ*WIDTH each  are the packed operands, requester k at bits [k*WIDTH +: WIDTH].
REQ-009 Port u_start / u_op  output  1 / 1  is the one-cycle start pulse and the operation to the shared rational unit.
REQ-010 Port u_l_num / u_l_den / u_r_num / u_r_den  output  WIDTH each  are the latched operands to the unit.
REQ-011 Port u_rdy  input  1  is unit result valid; u_s_num / u_s_den  input  WIDTH each  are the unit results.
REQ-012 Port resp_valid / resp_ready  output / input  1 / 1  is the response handshake.
REQ-013 Port resp_id  output  clog2(NREQ)  identifies the requester served.
REQ-014 Port resp_num / resp_den / resp_err  output  WIDTH / WIDTH / 1  are the result and error flag.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-016 In IDLE with any req_valid high, the block SHALL assert req_ready for exactly one granted requester, latch its op and operands, and go to ISSUE on the next edge.
REQ-017 Grant SHALL be round-robin, searching from (last_grant+1) mod NREQ upward with wrap-around; last_grant resets to NREQ-1, so requester 0 wins first.
REQ-018 req_ready SHALL be low in every state except IDLE.
REQ-019 ISSUE SHALL last exactly one cycle with u_start=1, then go to WAIT; u_start SHALL be 0 in all other states.
REQ-020 u_op and u_* operands SHALL hold the latched values from ISSUE until the next grant.
REQ-021 In WAIT, on the first cycle u_rdy=1 the block SHALL capture u_s_num/u_s_den into resp_num/resp_den, set resp_err=0, and go to RESP.
REQ-022 In RESP, resp_valid SHALL be 1 and resp_* SHALL stay stable until resp_valid && resp_ready, after which the block returns to IDLE.
REQ-023 Minimum turnaround SHALL be 4 cycles (grant, ISSUE, WAIT with u_rdy, RESP with resp_ready); a new grant is possible in the following IDLE cycle.
REQ-024 u_rdy seen outside WAIT SHALL be ignored.
REQ-025 Requests that drop req_valid before grant SHALL be forgotten; no request queueing.

Reset
REQ-026 While rst=0: state=IDLE, req_ready=0, u_start=0, u_op=0, all u_* operands=0, resp_valid=0, resp_id=0, resp_num=0, resp_den=0, resp_err=0, last_grant=NREQ-1.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction with no response; the first grant after release follows REQ-017.

Configuration
REQ-028 With macro RAT_ARB_ZERO_DEN_CHK_EN defined, a granted request with l_den==0 or r_den==0 SHALL skip ISSUE/WAIT and go straight to RESP with resp_err=1, resp_num=0, resp_den=0.
REQ-029 Without the macro, zero denominators SHALL be issued to the unit unchanged, and resp_err SHALL be tied 0.

Structure
REQ-030 Package rat_pkg SHALL hold the op encoding constants (RAT_ADD=0, RAT_SUB=1) and the FSM state typedef.
REQ-031 Round-robin selection SHALL be a sub-module rat_rr_pick (inputs: request vector, last grant; outputs: one-hot grant, grant index, any).

Verification
REQ-032 Single request: req 2 add (1/2)+(1/3), unit returns 5/6 -> resp_id=2, 5/6, err=0, u_start exactly one pulse.
REQ-033 All four valid held high: grant order 0,1,2,3,0 across five transactions.
REQ-034 resp_ready held low 10 cycles in RESP -> resp_* stable, req_ready=0 throughout, then IDLE.
REQ-035 With macro: req 1 sub, r_den=0 -> resp_err=1, 0/0, u_start never pulses; without macro: u_start pulses, err=0.
REQ-036 rst low during WAIT -> all outputs at REQ-026 values; a later u_rdy causes no response.
